// File: rtl/mac_stream_accumulator.sv
// Purpose: sequences 4-lane x/w beats onto an external MAC wrapper and accumulates its sums into dot products.
// Latency: a beat issues one cycle after accept; a last beat accepted at edge t gives out_valid after edge t+1.
// Backpressure: in_ready drops for one cycle after every last beat and while a held result waits on out_ready.
module mac_stream_accumulator #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*bw-1:0]      in_x,
    input  logic [4*bw-1:0]      in_w,
    input  logic                 in_last,
    output logic [4*bw-1:0]      mac_x,
    output logic [4*bw-1:0]      mac_w,
    output logic [psum_bw-1:0]   mac_psum,
    input  logic [psum_bw-1:0]   mac_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [psum_bw-1:0]   out_data,
    output logic [7:0]           out_len
);

    localparam int         LANES   = 4;
    localparam logic [7:0] LEN_MAX = 8'hFF;

    // One beat as held in the issue stage: operands plus its end-of-vector marker.
    typedef struct packed {
        logic                last;
        logic [LANES*bw-1:0] x;
        logic [LANES*bw-1:0] w;
    } beat_t;

    beat_t              iss_beat;
    logic               iss_valid;
    logic [psum_bw-1:0] acc;
    logic [7:0]         beat_cnt;

    logic               iss_last_pending;
    logic               in_fire;
    logic               out_fire;
    logic               iss_accum;
    logic               iss_finish;
    logic [7:0]         beat_cnt_inc;

    // Handshake decode and the saturating beat count seen by the issuing beat.
    always_comb begin
        iss_last_pending = iss_valid && iss_beat.last;
        // A pending last beat will write the result buffer next edge, so hold
        // input off for that cycle; also never accept while a result is stuck.
        in_ready         = !iss_last_pending && (!out_valid || out_ready);
        in_fire          = in_valid && in_ready;
        out_fire         = out_valid && out_ready;
        iss_accum        = iss_valid && !iss_beat.last;
        iss_finish       = iss_valid && iss_beat.last;
        beat_cnt_inc     = (beat_cnt == LEN_MAX) ? LEN_MAX : (beat_cnt + 8'd1);
    end

    assign mac_x    = iss_beat.x;
    assign mac_w    = iss_beat.w;
    assign mac_psum = acc;

    // Accept stage: capture the beat into the issue register on a handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_beat  <= '0;
            iss_valid <= 1'b0;
        end else begin
            iss_valid <= in_fire;
            if (in_fire) begin
                iss_beat.x    <= in_x;
                iss_beat.w    <= in_w;
                iss_beat.last <= in_last;
            end
        end
    end

    // Issue stage: fold the wrapper's sum back into the accumulator, or clear it at vector end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (iss_accum) begin
            acc      <= mac_sum;
            beat_cnt <= beat_cnt_inc;
        end else if (iss_finish) begin
            acc      <= '0;
            beat_cnt <= '0;
        end
    end

    // Result buffer: a new result overrides a simultaneous consume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
        end else if (iss_finish) begin
            out_valid <= 1'b1;
            out_data  <= mac_sum;
            out_len   <= beat_cnt_inc;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_stream_accumulator.sv
`timescale 1ns/1ps
module tb_mac_stream_accumulator;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        in_last;
    logic [15:0] mac_x;
    logic [15:0] mac_w;
    logic [15:0] mac_psum;
    logic [15:0] mac_sum;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_len;

    mac_stream_accumulator #(.bw(4), .psum_bw(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_w     (in_w),
        .in_last  (in_last),
        .mac_x    (mac_x),
        .mac_w    (mac_w),
        .mac_psum (mac_psum),
        .mac_sum  (mac_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_len  (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dot product of one beat: unsigned x lanes times signed w lanes.
    function automatic int dot4(input logic [15:0] x, input logic [15:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            s += int'(x[i*4 +: 4]) * int'($signed(w[i*4 +: 4]));
        return s;
    endfunction

    // External MAC wrapper: psum plus dot product, wrapping at 16 bits.
    always_comb mac_sum = 16'(int'(mac_psum) + dot4(mac_x, mac_w));

    function automatic logic [15:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    typedef struct {
        logic [15:0] data;
        logic [7:0]  len;
    } result_t;

    result_t exp_q[$];
    int      vec_sum;
    int      vec_len;
    int      pass_cnt;
    int      fail_cnt;
    int      total_cnt;
    logic    last_in_fire;
    logic    last_out_fire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: observe handshakes at the falling edge, update model, return just after the rising edge.
    task automatic cycle();
        result_t r;
        @(negedge clk);
        last_in_fire  = reset && in_valid && in_ready;
        last_out_fire = reset && out_valid && out_ready;
        if (last_out_fire) begin
            check("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(r.data));
                check("out_len", 32'(out_len), 32'(r.len));
            end
        end
        if (last_in_fire) begin
            vec_sum += dot4(in_x, in_w);
            vec_len++;
            if (in_last) begin
                r.data = 16'(vec_sum);
                r.len  = (vec_len > 255) ? 8'd255 : 8'(vec_len);
                exp_q.push_back(r);
                vec_sum = 0;
                vec_len = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] x, input logic [15:0] w, input logic last,
                             output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_last  = last;
        do begin
            cycle();
            waited++;
        end while (!last_in_fire && waited < 20);
        check("beat_accepted", 32'(last_in_fire), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        vec_sum = 0;
        vec_len = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          w8;
        logic [15:0] ones;
        int          guard;
        logic        accepted;
        int          vlen;

        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        vec_sum = 0; vec_len = 0;
        reset = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0; in_last = 1'b0; out_ready = 1'b1;
        ones = pk(1, 1, 1, 1);

        // Reset state
        cycle(); cycle();
        check("rst_mac_x", 32'(mac_x), 32'd0);
        check("rst_mac_w", 32'(mac_w), 32'd0);
        check("rst_mac_psum", 32'(mac_psum), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        reset = 1'b1;
        cycle();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Three back-to-back beats, result 30, out_valid one edge after the last-beat accept edge
        send_beat(pk(1, 2, 3, 4), ones, 1'b0, w8);
        check("t1_b1_no_stall", 32'(w8), 32'd1);
        send_beat(pk(1, 2, 3, 4), ones, 1'b0, w8);
        check("t1_b2_no_stall", 32'(w8), 32'd1);
        send_beat(pk(1, 2, 3, 4), ones, 1'b1, w8);
        check("t1_b3_no_stall", 32'(w8), 32'd1);
        check("t1_not_yet_valid", 32'(out_valid), 32'd0);
        check("t1_bubble_in_ready", 32'(in_ready), 32'd0);
        cycle();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h001E);
        check("t1_len", 32'(out_len), 32'd3);
        check("t1_in_ready_back", 32'(in_ready), 32'd1);
        cycle();

        // Single beat, negative weights
        send_beat(pk(15, 15, 15, 15), pk(8, 8, 8, 8), 1'b1, w8);
        wait_out("t2");
        check("t2_data", 32'(out_data), 32'hFE20);
        check("t2_len", 32'(out_len), 32'd1);
        cycle();

        // Backpressure: first result held while the next vector's last beat waits
        out_ready = 1'b0;
        send_beat(pk(1, 2, 3, 4), ones, 1'b0, w8);
        send_beat(pk(1, 2, 3, 4), ones, 1'b0, w8);
        send_beat(pk(1, 2, 3, 4), ones, 1'b1, w8);
        wait_out("t3a");
        in_valid = 1'b1; in_x = pk(1, 2, 3, 4); in_w = ones; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t3_stall_in_ready", 32'(in_ready), 32'd0);
            check("t3_stall_no_accept", 32'(last_in_fire), 32'd0);
            check("t3_held_data", 32'(out_data), 32'h001E);
            check("t3_held_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("t3_accept_on_release", 32'(last_in_fire), 32'd1);
        in_valid = 1'b0;
        wait_out("t3b");
        check("t3b_data", 32'(out_data), 32'h000A);
        check("t3b_len", 32'(out_len), 32'd1);
        cycle();

        // Wrap-around and length saturation over 300 beats
        for (int b = 0; b < 300; b++)
            send_beat(pk(15, 15, 15, 15), pk(7, 7, 7, 7), (b == 299), w8);
        wait_out("t4");
        check("t4_data", 32'(out_data), 32'hEC30);
        check("t4_len", 32'(out_len), 32'd255);
        cycle();

        // Asynchronous reset mid-vector, then a fresh vector
        send_beat(pk(3, 5, 7, 9), pk(2, 3, 4, 5), 1'b0, w8);
        send_beat(pk(3, 5, 7, 9), pk(2, 3, 4, 5), 1'b0, w8);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_mac_x", 32'(mac_x), 32'd0);
        check("t5_rst_mac_w", 32'(mac_w), 32'd0);
        check("t5_rst_psum", 32'(mac_psum), 32'd0);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_out_data", 32'(out_data), 32'd0);
        check("t5_rst_out_len", 32'(out_len), 32'd0);
        model_reset();
        cycle();
        reset = 1'b1;
        cycle();
        send_beat(ones, pk(2, 2, 2, 2), 1'b1, w8);
        wait_out("t5");
        check("t5_data", 32'(out_data), 32'h0008);
        check("t5_len", 32'(out_len), 32'd1);
        cycle();

        // Bubbled input: valid every other cycle
        for (int b = 0; b < 4; b++) begin
            send_beat(pk(2, 0, 0, 0), pk(3, 0, 0, 0), (b == 3), w8);
            if (b != 3) cycle();
        end
        wait_out("t6");
        check("t6_data", 32'(out_data), 32'h0018);
        check("t6_len", 32'(out_len), 32'd4);
        cycle();

        // Randomized vectors with random valid gaps and output backpressure
        for (int v = 0; v < 25; v++) begin
            vlen = $urandom_range(1, 6);
            for (int b = 0; b < vlen; b++) begin
                in_x = 16'($urandom);
                in_w = 16'($urandom);
                in_last = (b == vlen - 1);
                accepted = 1'b0;
                guard = 0;
                while (!accepted && guard < 60) begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                    cycle();
                    accepted = last_in_fire;
                    guard++;
                end
                check("rand_beat_accepted", 32'(accepted), 32'd1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() > 0 || out_valid) && guard < 50) begin
            cycle();
            guard++;
        end
        check("rand_all_results_out", 32'(exp_q.size()), 32'd0);
        check("rand_buffer_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
